// File: rtl/cache_pkg.sv
// Shared types and width helpers for the direct-mapped cache controller.
// Index/tag widths are derived from the cache geometry via helper functions.
package cache_pkg;

  localparam int unsigned COUNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MEM_RD,
    S_MEM_WR,
    S_RESP
  } state_t;

  typedef logic req_id_t;

  function automatic int unsigned index_w(input int unsigned cache_size);
    return $clog2(cache_size);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_width,
                                        input int unsigned cache_size);
    return addr_width - $clog2(cache_size);
  endfunction

endpackage

// File: rtl/cache_rr_arbiter.sv
// Two-way round-robin arbiter. Grant is combinational; the last-granted id
// is remembered only when the caller strobes i_update.
module cache_rr_arbiter
  import cache_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output req_id_t    o_grant_id,
  output logic       o_grant_valid
);

  req_id_t r_last_grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (i_update && o_grant_valid) begin
      r_last_grant <= o_grant_id;
    end
  end

  // Under contention the requester not served last wins; otherwise the sole requester.
  always_comb begin
    o_grant_valid = |i_req;
    if (&i_req) begin
      o_grant_id = ~r_last_grant;
    end else begin
      o_grant_id = i_req[1];
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache shared by two
// requesters, with refill sequencing and saturating hit/miss statistics.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CACHE_SIZE = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [2*DATA_WIDTH-1:0] wdata,
  input  logic                    flush,
  output logic [1:0]              ack,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [COUNT_W-1:0]      hit_count,
  output logic [COUNT_W-1:0]      miss_count
);

  localparam int unsigned INDEX_W = index_w(CACHE_SIZE);
  localparam int unsigned TAG_W   = tag_w(ADDR_WIDTH, CACHE_SIZE);

  state_t r_state;
  state_t w_state_nxt;

  req_id_t                 r_id;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;

  logic [DATA_WIDTH-1:0]   r_line_data [CACHE_SIZE];
  logic [TAG_W-1:0]        r_line_tag  [CACHE_SIZE];
  logic [CACHE_SIZE-1:0]   r_valid;

  logic [INDEX_W-1:0]      w_index;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_hit;
  req_id_t                 w_grant_id;
  logic                    w_grant_valid;
  logic                    w_grant;
  logic                    w_lookup_rd;
  logic                    w_fill;

  logic [1:0]              w_ack_nxt;
  logic                    w_mem_req_nxt;
  logic                    w_mem_we_nxt;
  logic [ADDR_WIDTH-1:0]   w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0]   w_mem_wdata_nxt;
  logic [DATA_WIDTH-1:0]   w_rdata_nxt;

  assign w_index     = r_addr[INDEX_W-1:0];
  assign w_tag       = r_addr[ADDR_WIDTH-1:INDEX_W];
  assign w_hit       = r_valid[w_index] && (r_line_tag[w_index] == w_tag);
  assign w_grant     = (r_state == S_IDLE) && !flush && w_grant_valid;
  assign w_lookup_rd = (r_state == S_LOOKUP) && !r_we;
  assign w_fill      = (r_state == S_MEM_RD) && mem_ack;

  cache_rr_arbiter u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (req),
    .i_update     (w_grant),
    .o_grant_id   (w_grant_id),
    .o_grant_valid(w_grant_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (!flush && w_grant_valid) w_state_nxt = S_LOOKUP;
      S_LOOKUP: begin
        if (r_we)       w_state_nxt = S_MEM_WR;
        else if (w_hit) w_state_nxt = S_RESP;
        else            w_state_nxt = S_MEM_RD;
      end
      S_MEM_RD: if (mem_ack) w_state_nxt = S_RESP;
      S_MEM_WR: if (mem_ack) w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the upcoming state.
  always_comb begin
    w_ack_nxt       = '0;
    w_mem_req_nxt   = (w_state_nxt == S_MEM_RD) || (w_state_nxt == S_MEM_WR);
    w_mem_we_nxt    = (w_state_nxt == S_MEM_WR);
    w_mem_addr_nxt  = mem_addr;
    w_mem_wdata_nxt = mem_wdata;
    w_rdata_nxt     = rdata;
    if (w_mem_req_nxt) begin
      w_mem_addr_nxt = r_addr;
    end
    if (w_state_nxt == S_MEM_WR) begin
      w_mem_wdata_nxt = r_wdata;
    end
    if (w_state_nxt == S_RESP) begin
      w_ack_nxt[r_id] = 1'b1;
    end
    if (w_lookup_rd && w_hit) begin
      w_rdata_nxt = r_line_data[w_index];
    end else if (w_fill) begin
      w_rdata_nxt = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack       <= '0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ack       <= w_ack_nxt;
      rdata     <= w_rdata_nxt;
      mem_req   <= w_mem_req_nxt;
      mem_we    <= w_mem_we_nxt;
      mem_addr  <= w_mem_addr_nxt;
      mem_wdata <= w_mem_wdata_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_id    <= w_grant_id;
      r_we    <= w_grant_id ? we[1] : we[0];
      r_addr  <= w_grant_id ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
      r_wdata <= w_grant_id ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if ((r_state == S_IDLE) && flush) begin
      r_valid <= '0;
    end else if (w_fill) begin
      r_valid[w_index] <= 1'b1;
    end
  end

  // Data/tag arrays need no reset: their contents are gated by r_valid.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_line_data[w_index] <= mem_rdata;
      r_line_tag[w_index]  <= w_tag;
    end else if ((r_state == S_LOOKUP) && r_we && w_hit) begin
      r_line_data[w_index] <= r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (w_lookup_rd) begin
      if (w_hit) begin
        if (hit_count != '1) hit_count <= hit_count + 1'b1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: a behavioural cache/memory model predicts
// hit/miss, read data, latency, memory traffic and grant order.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        flush = 1'b0;
  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cache_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .CACHE_SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .flush(flush), .ack(ack), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  // Backing memory: acks after mem_wait idle cycles of mem_req.
  logic [7:0] mem_env [256];
  int mem_wait = 0;
  int wait_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      wait_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (wait_cnt >= mem_wait) begin
        mem_ack = 1'b1;
        wait_cnt = 0;
        if (mem_we) mem_env[mem_addr] = mem_wdata;
        else        mem_rdata = mem_env[mem_addr];
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Reference model
  logic [7:0] ref_mem [256];
  bit         m_valid [16];
  logic [3:0] m_tag   [16];
  logic [7:0] m_data  [16];
  int         exp_hits = 0;
  int         exp_miss = 0;
  int         m_last = 1;
  logic [7:0] m_rdata = '0;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 0;
    exp_hits = 0;
    exp_miss = 0;
    m_last = 1;
    m_rdata = '0;
  endfunction

  function automatic void model_access(input bit w, input logic [7:0] a,
                                       input logic [7:0] d, output bit hit);
    int idx = a % 16;
    logic [3:0] tg = 4'(a / 16);
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (w) begin
      if (hit) m_data[idx] = d;
      ref_mem[a] = d;
    end else if (hit) begin
      exp_hits++;
      m_rdata = m_data[idx];
    end else begin
      exp_miss++;
      m_valid[idx] = 1;
      m_tag[idx] = tg;
      m_data[idx] = ref_mem[a];
      m_rdata = ref_mem[a];
    end
  endfunction

  task automatic check_counts(input string name);
    n_cmp++;
    if (hit_count !== 16'(sat16(exp_hits))) begin
      n_fail++;
      $display("FAIL %s hit_count: got %0d expected %0d", name, hit_count, sat16(exp_hits));
    end
    n_cmp++;
    if (miss_count !== 16'(sat16(exp_miss))) begin
      n_fail++;
      $display("FAIL %s miss_count: got %0d expected %0d", name, miss_count, sat16(exp_miss));
    end
  endtask

  task automatic run_txn(input int id, input bit w, input logic [7:0] a,
                         input logic [7:0] d, input int waits, input string name);
    bit hit;
    int lat = 0;
    int mcyc = 0;
    bit seen = 0;
    bit mem_ok = 1;
    int exp_lat;
    model_access(w, a, d, hit);
    m_last = id;
    mem_wait = waits;
    @(negedge clk);
    req[id] = 1'b1;
    we[id] = w;
    addr[id*8 +: 8] = a;
    wdata[id*8 +: 8] = d;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (mem_req) begin
        mcyc++;
        if (mem_we !== w || mem_addr !== a || (w && mem_wdata !== d)) mem_ok = 0;
      end
      if (ack !== 2'b00) seen = 1;
    end
    exp_lat = (hit && !w) ? 2 : 3 + waits;
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: no ack after %0d cycles, required ack", name, lat);
    end
    n_cmp++;
    if (ack !== 2'(1 << id)) begin
      n_fail++;
      $display("FAIL %s ack: got %b expected %b", name, ack, 2'(1 << id));
    end
    n_cmp++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    n_cmp++;
    if (mcyc != ((hit && !w) ? 0 : waits + 1)) begin
      n_fail++;
      $display("FAIL %s mem_req cycles: got %0d expected %0d", name, mcyc,
               (hit && !w) ? 0 : waits + 1);
    end
    n_cmp++;
    if (!mem_ok) begin
      n_fail++;
      $display("FAIL %s mem port: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
               name, mem_we, mem_addr, mem_wdata, w, a, d);
    end
    n_cmp++;
    if (rdata !== m_rdata) begin
      n_fail++;
      $display("FAIL %s rdata: got %h expected %h", name, rdata, m_rdata);
    end
    check_counts(name);
    req[id] = 1'b0;
    we[id] = 1'b0;
  endtask

  task automatic check_zero_outputs(input string name);
    n_cmp++;
    if ({ack, rdata, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count} !== '0) begin
      n_fail++;
      $display("FAIL %s outputs: got ack=%b rdata=%h mreq=%b mwe=%b maddr=%h mwd=%h hc=%0d mc=%0d expected all 0",
               name, ack, rdata, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_cold_and_conflict();
    run_txn(0, 0, 8'h25, 8'h00, 2, "cold_read");
    run_txn(0, 0, 8'h25, 8'h00, 1, "hit_after_fill");
    run_txn(0, 0, 8'h35, 8'h00, 0, "conflict_miss");
    run_txn(1, 1, 8'h35, 8'h3C, 1, "write_through");
    run_txn(1, 0, 8'h35, 8'h00, 0, "read_after_write");
    run_txn(0, 1, 8'h45, 8'h77, 0, "write_miss_noalloc");
    run_txn(0, 0, 8'h35, 8'h00, 0, "still_cached");
  endtask

  task automatic test_contention();
    logic [7:0] ca [2];
    bit hit;
    int exp_id;
    int cyc;
    rst_n = 1'b0;
    ca[0] = 8'($urandom);
    ca[1] = 8'($urandom);
    req = 2'b11;
    we = 2'b00;
    addr = {ca[1], ca[0]};
    mem_wait = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      exp_id = (m_last == 1) ? 0 : 1;
      model_access(0, ca[exp_id], 8'h00, hit);
      m_last = exp_id;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (ack === 2'b00 && cyc < 100);
      n_cmp++;
      if (ack !== 2'(1 << exp_id)) begin
        n_fail++;
        $display("FAIL contention grant %0d: got ack=%b expected %b", k, ack, 2'(1 << exp_id));
      end
      n_cmp++;
      if (rdata !== m_rdata) begin
        n_fail++;
        $display("FAIL contention rdata %0d: got %h expected %h", k, rdata, m_rdata);
      end
    end
    req = 2'b00;
    check_counts("contention");
  endtask

  task automatic test_flush();
    bit hit;
    run_txn(0, 0, 8'h5A, 8'h00, 1, "flush_fill");
    @(negedge clk);
    flush = 1'b1;
    req[1] = 1'b1;
    addr[15:8] = 8'h5A;
    @(negedge clk);
    flush = 1'b0;
    req[1] = 1'b0;
    n_cmp++;
    if (mem_req !== 1'b0 || ack !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_beats_req: got mem_req=%b ack=%b expected 0 00", mem_req, ack);
    end
    for (int i = 0; i < 16; i++) m_valid[i] = 0;
    hit = 0;
    run_txn(1, 0, 8'h5A, 8'h00, 0, "read_after_flush");
  endtask

  task automatic test_reset_mid_refill();
    int cyc = 0;
    run_txn(0, 0, 8'h13, 8'h00, 0, "prefill");
    mem_wait = 10;
    @(negedge clk);
    req[0] = 1'b1;
    we[0] = 1'b0;
    addr[7:0] = 8'h93;
    while (!mem_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (!mem_req) begin
      n_fail++;
      $display("FAIL refill_start: got mem_req=0 expected 1");
    end
    @(negedge clk);
    rst_n = 1'b0;
    req[0] = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset_mid_refill");
    rst_n = 1'b1;
    model_reset();
    repeat (12) @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b0 || ack !== 2'b00) begin
      n_fail++;
      $display("FAIL abandoned_txn: got mem_req=%b ack=%b expected 0 00", mem_req, ack);
    end
    run_txn(1, 0, 8'h13, 8'h00, 1, "miss_after_reset");
  endtask

  task automatic test_random();
    logic [7:0] pool [4];
    pool[0] = 8'h25; pool[1] = 8'h35; pool[2] = 8'h16;
    for (int n = 0; n < 40; n++) begin
      pool[3] = 8'($urandom);
      run_txn(int'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3),
              pool[$urandom_range(0, 3)], 8'($urandom),
              int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_env[i] = 8'($urandom);
      ref_mem[i] = mem_env[i];
    end
    mem_env[8'h25] = 8'hA5;
    ref_mem[8'h25] = 8'hA5;
    test_reset();
    test_cold_and_conflict();
    test_contention();
    test_flush();
    test_reset_mid_refill();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Direct-mapped cache controller that shares one cache array and one backing-memory port between two requesters. It arbitrates round-robin, performs tag lookup, sequences line refill on read misses and write-through on writes, and reports hit/miss statistics. It sits between the ALU-side load/store and operand-fetch units and the memory interface.

## Interface

- ADDR_WIDTH, 8, byte address width
- DATA_WIDTH, 8, data word width (one word per line)
- CACHE_SIZE, 16, number of lines, power of two, ≥2

- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- req  in  2  per-requester request; held until that requester's ack
- we  in  2  per-requester write enable, qualified by req
- addr  in  2×ADDR_WIDTH  packed per-requester address; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  in  2×DATA_WIDTH  packed per-requester write data
- flush  in  1  invalidate all lines; acted on only in IDLE
- ack  out  2  one-cycle completion pulse per requester
- rdata  out  DATA_WIDTH  read data, valid when an ack bit is high
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ack  in  1  memory completion, single cycle
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack
- hit_count  out  16  saturating read-hit counter
- miss_count  out  16  saturating read-miss counter

## Operation

- INDEX_W = $clog2(CACHE_SIZE). index = addr[INDEX_W-1:0]; tag = addr[ADDR_WIDTH-1:INDEX_W]. Per line: data, tag, valid bit.
- FSM states: IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
- IDLE: if flush, clear all valid bits and stay in IDLE; flush beats requests. Else if any req, grant one requester, latch id/we/addr/wdata, and go to LOOKUP.
- Arbitration: round-robin on last_grant. If only one requester is active, it wins. If both are active, the one not last granted wins. last_grant resets to 1, so requester 0 wins the first contention.
- LOOKUP: hit = valid[index] && tag match.
  - Read hit: increment hit_count, load rdata from the line, go to RESP.
  - Read miss: increment miss_count, go to MEM_RD.
  - Write (hit or miss): if hit, update line data. Go to MEM_WR. No write-allocate.
- MEM_RD: mem_req=1, mem_we=0, mem_addr = latched addr. On mem_ack, fill the line (data, tag, valid=1), load rdata=mem_rdata, go to RESP.
- MEM_WR: mem_req=1, mem_we=1, mem_wdata = latched wdata. On mem_ack, go to RESP.
- RESP: ack[granted]=1 for exactly this cycle, then go to IDLE. rdata holds its value until the next load.
- Counters saturate at 16'hFFFF. Writes count toward neither counter.

## Timing

- Reset (rst_n low at an edge):
  - State returns to IDLE from any state, including mid-MEM_RD and mid-MEM_WR.
  - All valid bits clear, last_grant=1, counters=0.
  - ack, rdata, mem_req, mem_we, mem_addr and mem_wdata all reset to 0. An outstanding memory transaction is abandoned.
- All outputs are registered.
- Read hit: req sampled in IDLE at edge 0, LOOKUP in cycle 1, ack high in cycle 2. Latency is 2 cycles from grant.
- Miss or write: mem_req rises in the cycle after LOOKUP and stays high until the edge that samples mem_ack. ack follows in the next cycle. Latency is 3 + memory wait cycles.
- The requester drops req at the edge ending its ack cycle, so IDLE never re-grants a completed request. A requester holding req continuously gets one transaction per grant, and round-robin alternates under contention.
- mem_ack outside MEM_RD/MEM_WR is ignored.
- A flush arriving while the FSM is busy is not latched. The flush source holds it until the FSM returns to IDLE.

## Structure

- Shared package cache_pkg holds:
  - the state enum typedef
  - localparam derivation of INDEX_W and TAG_W
  - a requester-id typedef (1 bit)
  - COUNT_W = 16
- Sub-module cache_rr_arbiter: 2-way round-robin. Inputs: req[1:0], update strobe. Outputs: grant id, grant valid. Owns the last_grant register.
- Line storage uses flop arrays. The valid vector is a separate register so flush clears it in one cycle.

## Test plan

- Cold read: requester 0 reads addr 8'h25 with memory returning 8'hA5 after 2 wait cycles → mem_req for 3 cycles with mem_addr=8'h25; ack[0] follows with rdata=8'hA5; miss_count=1.
- Hit after fill: repeat the 8'h25 read → ack[0] 2 cycles after grant, rdata=8'hA5, no mem_req; hit_count=1.
- Conflict and write-through:
  - Read 8'h35 (same index, different tag) → miss; refill evicts the line.
  - Write 8'h35 with data 8'h3C → mem_we=1, mem_wdata=8'h3C.
  - Next read of 8'h35 → hit returning 8'h3C.
- Contention: both requesters hold req from reset → grant order 0,1,0,1; each ack is on the correct bit; no lost request.
- Flush: after a fill, pulse flush in IDLE → the next read of the same address misses; miss_count increments.
- Reset mid-refill: drop rst_n during MEM_RD → next cycle mem_req=0, ack=0, counters=0; a following read of a previously filled address misses.
